sequence_gen: RTL

SEQUENCE_GEN -- requirements
Module: sequence_gen

---
 rtl/sequence_gen_pkg.sv | 15 +
 rtl/seq_shift_reg.sv | 39 +++
 rtl/sequence_gen.sv | 125 ++++++++++++
 3 files changed

// File: rtl/sequence_gen_pkg.sv
// Shared state encoding for the serial pattern generator and the benches that
// drive or observe it.
package sequence_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_GAP   = 3'd2,
    ST_DONE  = 3'd3
  } state_t;

  localparam int REPS_W = 3;
  localparam int GAP_W  = 3;

endpackage

// File: rtl/seq_shift_reg.sv
// Pattern shift register with a captured copy for reloading between repetitions.
// msb_next is the bit that will sit at the MSB after the coming edge.
module seq_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             reload,
  input  logic             shift,
  input  logic [WIDTH-1:0] pattern,
  output logic             msb_next
);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] cap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      cap <= '0;
    end else if (load) begin
      sr  <= pattern;
      cap <= pattern;
    end else if (reload) begin
      sr <= cap;
    end else if (shift) begin
      sr <= {sr[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    msb_next = sr[WIDTH-1];
    if (load)        msb_next = pattern[WIDTH-1];
    else if (reload) msb_next = cap[WIDTH-1];
    else if (shift)  msb_next = sr[WIDTH-2];
  end

endmodule

// File: rtl/sequence_gen.sv
// Serial pattern generator: sends PATTERN MSB first REPS+1 times with idle gaps,
// then pulses DONE. All outputs come straight from flops.
//
// state    | meaning
// IDLE     | waiting for START
// SHIFT    | emitting one pattern bit per cycle
// GAP      | idle cycles between repetitions
// DONE     | one-cycle completion pulse
module sequence_gen
  import sequence_gen_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic [WIDTH-1:0] PATTERN,
  input  logic [2:0]       REPS,
  output logic             X,
  output logic             X_VALID,
  output logic             BUSY,
  output logic             DONE,
  output logic [2:0]       S
);

  localparam int BW = $clog2(WIDTH + 1);

  state_t          state;
  logic [BW-1:0]   bit_cnt;
  logic [2:0]      rep_cnt;
  logic [2:0]      gap_cnt;
  logic            load;
  logic            last;
  logic            shift;
  logic            reload;
  logic            msb_next;

  assign load   = (state == ST_IDLE) && START;
  assign last   = (state == ST_SHIFT) && (bit_cnt == BW'(WIDTH - 1));
  assign shift  = (state == ST_SHIFT) && !last;
  assign reload = last && (rep_cnt != '0);
  assign S      = state;

  seq_shift_reg #(.WIDTH(WIDTH)) u_shift_reg (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .load     (load),
    .reload   (reload),
    .shift    (shift),
    .pattern  (PATTERN),
    .msb_next (msb_next)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      rep_cnt <= '0;
      gap_cnt <= '0;
      X       <= 1'b0;
      X_VALID <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      X       <= 1'b0;
      X_VALID <= 1'b0;
      DONE    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START) begin
            state   <= ST_SHIFT;
            rep_cnt <= REPS;
            bit_cnt <= '0;
            X       <= msb_next;
            X_VALID <= 1'b1;
            BUSY    <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (!last) begin
            bit_cnt <= bit_cnt + 1'b1;
            X       <= msb_next;
            X_VALID <= 1'b1;
          end else if (rep_cnt == '0) begin
            state <= ST_DONE;
            DONE  <= 1'b1;
          end else begin
            rep_cnt <= rep_cnt - 1'b1;
            bit_cnt <= '0;
            // With no gap the reloaded MSB goes out on the very next cycle.
            if (GAP_CYCLES == 0) begin
              X       <= msb_next;
              X_VALID <= 1'b1;
            end else begin
              state   <= ST_GAP;
              gap_cnt <= 3'(GAP_CYCLES - 1);
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) begin
            state   <= ST_SHIFT;
            X       <= msb_next;
            X_VALID <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
        end
        default: begin
          state   <= ST_IDLE;
          BUSY    <= 1'b0;
          bit_cnt <= '0;
          rep_cnt <= '0;
          gap_cnt <= '0;
        end
      endcase
    end
  end

endmodule
